csr_rmw_unit: RTL
=================

Name: csr_rmw_unit

Overview:
- Sequences RISC-V Zicsr instructions (CSRRW/S/C and immediate forms) against the registered-read CSR file.
- Sits between the decode/execute stage and csr_file.
- Drives the CSR file's read address, waits out its 1-cycle read latency, computes the new value, and issues a single write.
- Returns the old CSR value for rd writeback.

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand
- ADDR_W, 12, CSR address width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle, accepts request this cycle
- req_funct3  input  3  Zicsr funct3
- req_addr  input  ADDR_W  target CSR address
- req_src  input  5  rs1 index (register forms) or zimm (immediate forms)
- req_rs1val  input  XLEN  rs1 register value
- resp_valid  output  1  one-cycle pulse: response valid
- resp_rdval  output  XLEN  old CSR value for rd
- resp_illegal  output  1  illegal-access flag, qualified by resp_valid
- csr_rdAddr  output  ADDR_W  to CSR file read address
- csr_rdVal  input  XLEN  from CSR file, registered read data
- csr_write  output  1  to CSR file write enable
- csr_wrAddr  output  ADDR_W  to CSR file write address
- csr_wrVal  output  XLEN  to CSR file write data

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdval=0, resp_illegal=0, csr_write=0, csr_rdAddr=0, csr_wrAddr=0, csr_wrVal=0.
- FSM states: IDLE -> RD_WAIT -> MODIFY -> RESP -> IDLE.
- req_ready=1 only in IDLE; handshake is req_valid & req_ready at a rising edge (edge E0).
- At E0: latch funct3, addr, src, rs1val; state becomes RD_WAIT.
- csr_rdAddr is driven from the latched address and held stable from E0 until IDLE.
- RD_WAIT: the CSR file samples csr_rdAddr at E1; state becomes MODIFY.
- MODIFY: csr_rdVal (old value) is valid and feeds the combinational modify logic.
- Operand: req_rs1val for funct3[2]=0; zero-extended req_src for funct3[2]=1.
- Modify functions:
  - 001/101 (W): new = operand.
  - 010/110 (S): new = old | operand.
  - 011/111 (C): new = old & ~operand.
- Write enable:
  - W forms always write, including when rd=x0.
  - S/C forms write only when req_src != 0.
  - funct3 000/100 never write.
- csr_write is asserted combinationally in MODIFY only, with csr_wrAddr = latched address and csr_wrVal = new value; the write commits at E2.
- At E2: resp_rdval <= old value; resp_valid <= 1; state becomes RESP.
- RESP: resp_valid high for exactly one cycle; next edge returns to IDLE with resp_valid=0. resp_rdval holds its value until the next response.
- Timing: latency is accept to resp_valid = 3 cycles; throughput is one request per 4 cycles.
- No bypass is needed: the write completes before the next request's read address is presented.
- Reset mid-operation: returns to IDLE immediately. No write issues after reset asserts, and no resp_valid is produced for the aborted request.
- req_valid outside IDLE is ignored; the requester must hold it until accepted.

Optional Feature:
- Macro: CSR_RMW_UNIT_RO_TRAP_EN.
- Defined:
  - An access is illegal if it would write to a read-only CSR (req_addr[11:10]==2'b11), or if funct3 is 000/100.
  - An illegal access suppresses csr_write and raises resp_illegal with resp_valid; resp_rdval still carries the old value.
  - A read-only CSR with S/C and src=0 is legal.
- Undefined:
  - resp_illegal is tied 0.
  - Writes to 11xx addresses proceed normally.
  - funct3 000/100 is a silent no-write read.

Decomposition:
- Shared package/header csr_defs holds:
  - funct3 encodings (CSRRW=001, CSRRS=010, CSRRC=011, immediate forms with bit 2 set)
  - FSM state encodings
  - read-only prefix constant 2'b11
  - XLEN default
- Sub-module csr_rmw_alu: purely combinational; takes (funct3, old, rs1val, src); produces (new value, write-enable, illegal).

Test Plan:
- Reset, then CSRRW addr=0x340, rs1val=0xDEADBEEF with the CSR pre-set to 0x12345678 -> write asserted at cycle 2 with 0xDEADBEEF; resp_valid at cycle 3 with resp_rdval=0x12345678.
- CSRRS addr=0x300, src=5, rs1val=0x00000008, old=0x00000001 -> csr_wrVal=0x00000009; CSRRC, same operands, old=0x0F -> csr_wrVal=0x07.
- CSRRS src=0 and CSRRCI zimm=0 -> csr_write never asserts; resp_rdval equals the old value.
- CSRRWI addr=0x341, zimm=0x1F -> csr_wrVal=0x0000001F; back-to-back request held high -> second accept exactly 4 cycles after the first.
- Reset asserted during MODIFY -> csr_write drops the same cycle; no resp_valid; req_ready=1 after release.
- With CSR_RMW_UNIT_RO_TRAP_EN: CSRRW addr=0xC00 -> resp_illegal=1, no write. CSRRS addr=0xC00, src=0 -> legal, resp_illegal=0. Without the macro: CSRRW addr=0xC00 writes and resp_illegal=0.

Source files
------------

// File: rtl/csr_rmw_unit_pkg.sv
// Shared CSR read-modify-write definitions: Zicsr funct3 encodings, FSM state
// encodings, the read-only address prefix and default widths.
package csr_rmw_unit_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 12;

  // Zicsr funct3; bit 2 selects the immediate (zimm) operand form
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_MODIFY  = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Top two address bits of a read-only CSR
  localparam logic [1:0] RO_PREFIX = 2'b11;

endpackage

// File: rtl/csr_rmw_unit_alu.sv
// Combinational modify stage for the CSR read-modify-write sequencer.
// Computes the new CSR value, whether a write should issue, and whether the
// access is illegal. Read-only trapping is built only when
// CSR_RMW_UNIT_RO_TRAP_EN is defined.
module csr_rmw_alu
  import csr_rmw_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   oldVal,
  input  logic [XLEN-1:0]   rs1Val,
  input  logic [4:0]        src,
  output logic [XLEN-1:0]   newVal,
  output logic              wrEn,
  output logic              illegal
);

  logic [XLEN-1:0] operand;
  logic            wantWrite;
  logic            srcNz;

  assign srcNz = |src;

  // Operand select and modify function; S/C with a zero source is a pure read
  always_comb begin
    operand   = funct3[2] ? {{(XLEN-5){1'b0}}, src} : rs1Val;
    newVal    = oldVal;
    wantWrite = 1'b0;
    case (funct3[1:0])
      2'b01: begin
        newVal    = operand;
        wantWrite = 1'b1;
      end
      2'b10: begin
        newVal    = oldVal | operand;
        wantWrite = srcNz;
      end
      2'b11: begin
        newVal    = oldVal & ~operand;
        wantWrite = srcNz;
      end
      default: begin
        newVal    = oldVal;
        wantWrite = 1'b0;
      end
    endcase
  end

`ifdef CSR_RMW_UNIT_RO_TRAP_EN
  logic roAddr;
  assign roAddr = (addr[ADDR_W-1:ADDR_W-2] == RO_PREFIX);

  // Illegal: an actual write to a read-only CSR, or a non-Zicsr funct3
  always_comb begin
    illegal = (roAddr & wantWrite) | (funct3[1:0] == 2'b00);
    wrEn    = wantWrite & ~illegal;
  end
`else
  logic unusedAddr;
  assign unusedAddr = ^addr;

  // No trapping: every requested write goes through
  always_comb begin
    illegal = 1'b0;
    wrEn    = wantWrite;
  end
`endif

endmodule

// File: rtl/csr_rmw_unit.sv
// Zicsr read-modify-write sequencer in front of a registered-read CSR file.
// IDLE -> RD_WAIT (CSR file samples address) -> MODIFY (write issues) ->
// RESP (one-cycle response pulse) -> IDLE. Optional read-only trapping via
// CSR_RMW_UNIT_RO_TRAP_EN.
module csr_rmw_unit
  import csr_rmw_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_src,
  input  logic [XLEN-1:0]   req_rs1val,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdval,
  output logic              resp_illegal,
  output logic [ADDR_W-1:0] csr_rdAddr,
  input  logic [XLEN-1:0]   csr_rdVal,
  output logic              csr_write,
  output logic [ADDR_W-1:0] csr_wrAddr,
  output logic [XLEN-1:0]   csr_wrVal
);

  logic [1:0]        state;
  logic [2:0]        funct3Q;
  logic [ADDR_W-1:0] addrQ;
  logic [4:0]        srcQ;
  logic [XLEN-1:0]   rs1Q;

  logic [XLEN-1:0]   aluNew;
  logic              aluWrEn;
  logic              aluIllegal;
  logic              inModify;

  csr_rmw_alu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) uAlu (
    .funct3 (funct3Q),
    .addr   (addrQ),
    .oldVal (csr_rdVal),
    .rs1Val (rs1Q),
    .src    (srcQ),
    .newVal (aluNew),
    .wrEn   (aluWrEn),
    .illegal(aluIllegal)
  );

  assign inModify = (state == ST_MODIFY);

  // CSR file interface; write strobe exists only in MODIFY so an async reset
  // kills an in-flight write immediately
  always_comb begin
    req_ready  = (state == ST_IDLE);
    csr_rdAddr = addrQ;
    csr_wrAddr = addrQ;
    csr_write  = inModify & aluWrEn;
    csr_wrVal  = inModify ? aluNew : '0;
  end

  // Sequencer, request latch and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      funct3Q      <= '0;
      addrQ        <= '0;
      srcQ         <= '0;
      rs1Q         <= '0;
      resp_valid   <= 1'b0;
      resp_rdval   <= '0;
      resp_illegal <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            funct3Q <= req_funct3;
            addrQ   <= req_addr;
            srcQ    <= req_src;
            rs1Q    <= req_rs1val;
            state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: state <= ST_MODIFY;
        ST_MODIFY: begin
          resp_valid   <= 1'b1;
          resp_rdval   <= csr_rdVal;
          resp_illegal <= aluIllegal;
          state        <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
